// File: rtl/ika87ad_opfetch_if.sv
// Opcode fetch bus: byte fetch handshake on one side,
// held opcode and sequencer control on the other.
interface ika87ad_opfetch_if;
  logic       i_FETCH_VLD;
  logic [7:0] i_FETCH_DATA;
  logic       o_FETCH_RDY;
  logic       o_PC_INC;
  logic       i_OP_ACK;
  logic       i_SKIP;
  logic       i_IRQ;
  logic       i_FLUSH;
  logic [7:0] o_OPCODE;
  logic [2:0] o_OPCODE_PAGE;
  logic       o_OP_VLD;
  logic       o_OP_SKIP;
  logic       o_OP_IRQ;

  modport master (
    input  i_FETCH_VLD, i_FETCH_DATA,
    output o_FETCH_RDY, o_PC_INC,
    input  i_OP_ACK, i_SKIP, i_IRQ, i_FLUSH,
    output o_OPCODE, o_OPCODE_PAGE,
    output o_OP_VLD, o_OP_SKIP, o_OP_IRQ
  );

  modport slave (
    output i_FETCH_VLD, i_FETCH_DATA,
    input  o_FETCH_RDY, o_PC_INC,
    output i_OP_ACK, i_SKIP, i_IRQ, i_FLUSH,
    input  o_OPCODE, o_OPCODE_PAGE,
    input  o_OP_VLD, o_OP_SKIP, o_OP_IRQ
  );
endinterface

// File: rtl/ika87ad_opfetch.sv
// Opcode fetch: folds prefix bytes into a page number,
// holds one opcode for the sequencer, injects HARDI on IRQ.
module ika87ad_opfetch (
  input  logic i_EMUCLK,
  input  logic i_RST,
  ika87ad_opfetch_if.master bus
);

  typedef enum logic [1:0] {
    S_OP1  = 2'd0,
    S_OP2  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [7:0] HARDI = 8'h73;

  state_t     r_state;
  logic [2:0] r_page;
  logic       r_skip_pend;
  logic [7:0] r_opcode;
  logic [2:0] r_opcode_page;
  logic       r_op_skip;
  logic       r_op_irq;
  logic       r_pc_inc;

  logic       w_irq_inj;
  logic       w_rdy;
  logic       w_acc;
  logic [2:0] w_pfx;

  always_comb begin
    w_pfx = 3'd0;
    unique case (bus.i_FETCH_DATA)
      8'h48:   w_pfx = 3'd1;
      8'h60:   w_pfx = 3'd2;
      8'h64:   w_pfx = 3'd3;
      8'h70:   w_pfx = 3'd4;
      8'h74:   w_pfx = 3'd5;
      default: w_pfx = 3'd0;
    endcase
  end

  // IRQ is only taken between instructions, never for a skipped one
  assign w_irq_inj = (r_state == S_OP1) & bus.i_IRQ
                   & ~r_skip_pend;
  assign w_rdy = (r_state != S_HOLD) & ~bus.i_FLUSH
               & ~w_irq_inj;
  assign w_acc = w_rdy & bus.i_FETCH_VLD;

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      r_state       <= S_OP1;
      r_page        <= 3'd0;
      r_skip_pend   <= 1'b0;
      r_opcode      <= 8'h00;
      r_opcode_page <= 3'd0;
      r_op_skip     <= 1'b0;
      r_op_irq      <= 1'b0;
      r_pc_inc      <= 1'b0;
    end else begin
      r_pc_inc <= w_acc;
      if (bus.i_FLUSH) begin
        r_state     <= S_OP1;
        r_page      <= 3'd0;
        r_skip_pend <= 1'b0;
        r_op_skip   <= 1'b0;
        r_op_irq    <= 1'b0;
      end else begin
        unique case (r_state)
          S_OP1: begin
            if (w_irq_inj) begin
              r_opcode      <= HARDI;
              r_opcode_page <= 3'd0;
              r_op_skip     <= 1'b0;
              r_op_irq      <= 1'b1;
              r_state       <= S_HOLD;
            end else if (w_acc) begin
              if (w_pfx != 3'd0) begin
                r_page  <= w_pfx;
                r_state <= S_OP2;
              end else begin
                r_opcode      <= bus.i_FETCH_DATA;
                r_opcode_page <= 3'd0;
                r_op_skip     <= r_skip_pend;
                r_skip_pend   <= 1'b0;
                r_op_irq      <= 1'b0;
                r_state       <= S_HOLD;
              end
            end
          end
          S_OP2: begin
            if (w_acc) begin
              r_opcode      <= bus.i_FETCH_DATA;
              r_opcode_page <= r_page;
              r_page        <= 3'd0;
              r_op_skip     <= r_skip_pend;
              r_skip_pend   <= 1'b0;
              r_op_irq      <= 1'b0;
              r_state       <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (bus.i_OP_ACK) begin
              r_state   <= S_OP1;
              r_op_skip <= 1'b0;
              r_op_irq  <= 1'b0;
              if (bus.i_SKIP) r_skip_pend <= 1'b1;
            end
          end
          default: r_state <= S_OP1;
        endcase
      end
    end
  end

  assign bus.o_FETCH_RDY   = w_rdy;
  assign bus.o_PC_INC      = r_pc_inc;
  assign bus.o_OPCODE      = r_opcode;
  assign bus.o_OPCODE_PAGE = r_opcode_page;
  assign bus.o_OP_VLD      = (r_state == S_HOLD);
  assign bus.o_OP_SKIP     = r_op_skip;
  assign bus.o_OP_IRQ      = r_op_irq;

endmodule
